uart_tx_engine: RTL and testbench

//  Serialising UART transmitter that drains the TX uart_fifo and drives the tx line.
//  - Pops one byte when the FIFO is non-empty and the engine is idle.
//  - Emits an async frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//  - Integer clock-divider baud generator.

---
 rtl/uart_tx_engine.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter engine: pops bytes from the TX FIFO and serialises them as
// start / data (LSB first) / optional parity / stop bits, timed by an integer
// clock divider.
module uart_tx_engine #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  // Bits above DATA_BITS-1 of the FIFO word are dropped before shifting/parity.
  localparam logic [7:0] DataMask = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            bit_end;
  logic [7:0]      data_masked;

  assign data_masked = fifo_data & DataMask;
  assign bit_end     = (cnt_q == CntMax);

  // State and datapath registers with synchronous reset; reset forces the line idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next-state, baud counter, shifter and FIFO pop strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    fifo_rd_en = 1'b0;

    // The divider free-runs in every bit-carrying state and wraps at CLK_DIV-1.
    if (state_q inside {StStart, StData, StParity, StStop}) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (enable && !fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = StLoad;
        end
      end

      // FIFO output is valid now, one cycle after the pop edge.
      StLoad: begin
        shreg_d   = data_masked;
        par_d     = (^data_masked) ^ PARITY_ODD;
        tx_d      = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = StStart;
      end

      StStart: begin
        if (bit_end) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end

      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            if (PARITY_EN) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      StParity: begin
        if (bit_end) begin
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = StStop;
        end
      end

      // bit_cnt is reused to count stop bits.
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == LastStop) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three instances (no parity, even parity, odd parity),
// a FIFO model per instance, and a frame monitor that checks every tx sample
// against the expected frame popped from a per-instance scoreboard queue.
module tb_uart_tx_engine;

  localparam int NDut = 3;
  localparam int Div  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;

  logic       fempty_w [NDut];
  logic [7:0] fdata_w  [NDut];
  logic       rd_en_w  [NDut];
  logic       tx_w     [NDut];
  logic       busy_w   [NDut];
  logic       done_w   [NDut];

  logic [7:0]  fmem [NDut][16];
  int unsigned fwr  [NDut] = '{default: 0};
  int unsigned frd  [NDut] = '{default: 0};

  exp_t        exp_q   [NDut][$];
  int          pos     [NDut] = '{default: -1};
  exp_t        cur     [NDut];
  logic [7:0]  dec     [NDut];
  logic        decp    [NDut];
  logic        wave_ok [NDut];
  int unsigned nframes [NDut] = '{default: 0};
  int unsigned nstarts [NDut] = '{default: 0};
  int unsigned st_log  [NDut][16];
  int unsigned cyc = 0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    uart_tx_engine #(
      .CLK_DIV   (Div),
      .DATA_BITS (8),
      .PARITY_EN (g != 0),
      .PARITY_ODD(g == 2),
      .STOP_BITS (1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fempty_w[g]),
      .fifo_data (fdata_w[g]),
      .fifo_rd_en(rd_en_w[g]),
      .tx        (tx_w[g]),
      .busy      (busy_w[g]),
      .tx_done   (done_w[g])
    );
    assign fempty_w[g] = (frd[g] == fwr[g]);
  end

  // FIFO model: data_out becomes valid the cycle after a pop edge.
  always @(posedge clk) begin
    for (int g = 0; g < NDut; g++) begin
      if (rd_en_w[g] === 1'b1) begin
        fdata_w[g] <= fmem[g][frd[g][3:0]];
        frd[g]     <= frd[g] + 1;
      end
    end
  end

  function automatic bit has_par(input int g);
    return g != 0;
  endfunction

  function automatic int frame_len(input int g);
    return (has_par(g) ? 11 : 10) * Div;
  endfunction

  function automatic logic exp_bit(input exp_t e, input int k, input bit pe);
    if (k == 0) return 1'b0;
    if (k <= 8) return e.data[k-1];
    if (pe && k == 9) return e.par;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, g, act, exp);
    end
  endtask

  task automatic mon_step(input int g);
    int fl;
    int k;
    fl = frame_len(g);
    chk("rd_en_legal", g, 32'(rd_en_w[g] & (fempty_w[g] | rst)), 32'd0);
    if (rst) begin
      pos[g] = -1;
      return;
    end
    if (pos[g] < 0) begin
      if (tx_w[g] === 1'b0) begin
        n_vec++;
        if (exp_q[g].size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_frame dut%0d: got start bit, expected idle line", g);
          cur[g] = '0;
        end else begin
          cur[g] = exp_q[g].pop_front();
        end
        pos[g]     = 0;
        wave_ok[g] = 1'b1;
        dec[g]     = '0;
        decp[g]    = 1'b0;
        st_log[g][nstarts[g][3:0]] = cyc;
        nstarts[g]++;
      end else begin
        chk("idle_tx_done", g, 32'(done_w[g]), 32'd0);
        return;
      end
    end
    if (pos[g] < fl) begin
      k = pos[g] / Div;
      if (tx_w[g] !== exp_bit(cur[g], k, has_par(g)) || done_w[g] !== 1'b0 ||
          busy_w[g] !== 1'b1) begin
        wave_ok[g] = 1'b0;
      end
      if (pos[g] % Div == Div / 2) begin
        if (k >= 1 && k <= 8) dec[g][k-1] = tx_w[g];
        if (has_par(g) && k == 9) decp[g] = tx_w[g];
      end
      pos[g]++;
    end else begin
      chk("data", g, 32'(dec[g]), 32'(cur[g].data));
      if (has_par(g)) chk("parity", g, 32'(decp[g]), 32'(cur[g].par));
      chk("waveform", g, 32'(wave_ok[g]), 32'd1);
      chk("end_tx_done", g, 32'(done_w[g]), 32'd1);
      chk("end_tx", g, 32'(tx_w[g]), 32'd1);
      chk("end_busy", g, 32'(busy_w[g]), 32'd0);
      nframes[g]++;
      pos[g] = -1;
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int g = 0; g < NDut; g++) mon_step(g);
    end
  end

  task automatic push(input int g, input logic [7:0] d, input logic p);
    exp_t e;
    @(negedge clk);
    fmem[g][fwr[g][3:0]] = d;
    fwr[g]++;
    e.data = d;
    e.par  = p;
    exp_q[g].push_back(e);
  endtask

  task automatic wait_frames(input int g, input int unsigned target, input int budget);
    int n;
    n = 0;
    while (nframes[g] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_done", g, nframes[g], target);
  endtask

  task automatic wait_pos(input int g, input int p, input int budget);
    int n;
    n = 0;
    while (pos[g] != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pos", g, 32'(pos[g]), 32'(p));
  endtask

  initial begin
    int unsigned p0;
    int unsigned s0;
    logic        bad;

    // Reset values.
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDut; g++) begin
      chk("reset_tx", g, 32'(tx_w[g]), 32'd1);
      chk("reset_busy", g, 32'(busy_w[g]), 32'd0);
      chk("reset_tx_done", g, 32'(done_w[g]), 32'd0);
      chk("reset_rd_en", g, 32'(rd_en_w[g]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Empty FIFO with enable high: nothing happens.
    enable = 1'b1;
    bad    = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_en_w[0] !== 1'b0) bad = 1'b1;
    end
    chk("idle_200", 0, 32'(bad), 32'd0);
    chk("idle_pops", 0, frd[0], 32'd0);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit.
    push(0, 8'hA5, 1'b0);
    wait_frames(0, 1, 100);
    chk("t1_pops", 0, frd[0], 32'd1);
    @(negedge clk);
    chk("t1_busy_after", 0, 32'(busy_w[0]), 32'd0);

    // Parity: 0x03 even -> 0, 0x03 odd -> 1, 0x07 even -> 1; 44-clock frames.
    push(1, 8'h03, 1'b0);
    push(2, 8'h03, 1'b1);
    push(1, 8'h07, 1'b1);
    wait_frames(1, 2, 300);
    wait_frames(2, 1, 100);

    // Preloaded FIFO: three back-to-back frames, 40-clock frame + 2 idle clocks apart.
    enable = 1'b0;
    p0     = frd[0];
    s0     = nstarts[0];
    push(0, 8'h00, 1'b0);
    push(0, 8'hFF, 1'b0);
    push(0, 8'h55, 1'b0);
    enable = 1'b1;
    wait_frames(0, 4, 400);
    chk("t3_pops", 0, frd[0] - p0, 32'd3);
    chk("t3_gap01", 0, st_log[0][4'(s0 + 1)] - st_log[0][4'(s0)], 32'd42);
    chk("t3_gap12", 0, st_log[0][4'(s0 + 2)] - st_log[0][4'(s0 + 1)], 32'd42);

    // Reset during data bit 3 (frame sample 17), then 0x3C must go out cleanly.
    push(0, 8'h96, 1'b0);
    wait_pos(0, 17, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_tx", 0, 32'(tx_w[0]), 32'd1);
    chk("rst_mid_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("rst_mid_tx_done", 0, 32'(done_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'h3C, 1'b0);
    wait_frames(0, 5, 200);

    // Drop enable in the start bit with two bytes queued.
    p0 = frd[0];
    push(0, 8'h81, 1'b0);
    push(0, 8'h42, 1'b0);
    wait_pos(0, 1, 50);
    enable = 1'b0;
    wait_frames(0, 6, 200);
    repeat (20) @(negedge clk);
    chk("t6_pops_held", 0, frd[0] - p0, 32'd1);
    chk("t6_busy_held", 0, 32'(busy_w[0]), 32'd0);
    enable = 1'b1;
    wait_frames(0, 7, 200);
    chk("t6_pops_total", 0, frd[0] - p0, 32'd2);

    repeat (5) @(negedge clk);
    for (int g = 0; g < NDut; g++) begin
      chk("scoreboard_empty", g, 32'(exp_q[g].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
